wasm_trunc_f64: RTL and testbench
=================================

# wasm_trunc_f64

Multi-cycle f64-to-integer truncation unit implementing `i32/i64.trunc_f64_s/u` and the `trunc_sat` variants. It accepts an IEEE 754 double and returns a zero-extended integer, or raises the WebAssembly conversion traps. It sits beside the f64 FPU in the execute stage. Both sides use a valid/ready handshake, and at most one operation is in flight at a time.

## Interface
- No parameters.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: abandons the in-flight operation; synchronous.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: unit can accept; equals (state == IDLE).
- `op` in 3: bit0 = unsigned, bit1 = 64-bit destination, bit2 = saturating.
- `operand` in 64: f64 source bits.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `result` out 64: integer result; 32-bit ops return `{32'h0, i32}`.
- `trap` out `trap_t` (wasm_pkg): TRAP_NONE, TRAP_INT_OVERFLOW or TRAP_INVALID_CONV.

## Operation
**States:** IDLE → DECODE → SHIFT → DONE → IDLE.
- **IDLE:** on `in_valid` with `!rst && !flush`, latch `operand` and `op`, then go to DECODE.
- **DECODE:** compute the following and register them:
  - classify NaN (exp = 7FF, mant ≠ 0), Inf, zero or subnormal (exp = 0);
  - `e = exp - 1023`;
  - `m = {1, mant}` (53 bits).
- **SHIFT:** compute the magnitude `mag` (64 bits):
  - exp = 0 or `e < 0` → `mag = 0`;
  - `0 ≤ e ≤ 52` → `mag = m >> (52 - e)`, truncating toward zero;
  - `53 ≤ e ≤ 63` → `mag = m << (e - 52)`;
  - `e ≥ 64` (including Inf) → overflow.
- **Range check** (applied to the truncated `mag`, sign = operand[63]):
  - s32: positive needs `mag ≤ 2^31-1`; negative needs `mag ≤ 2^31`.
  - u32: needs `mag ≤ 2^32-1`; negative is allowed only when `mag = 0`.
  - s64: positive needs `e ≤ 62`; negative needs `mag ≤ 2^63`.
  - u64: needs `e ≤ 63`; negative is allowed only when `mag = 0`.
- **Non-saturating outcomes:**
  - NaN → TRAP_INVALID_CONV, `result = 0`.
  - Out of range → TRAP_INT_OVERFLOW, `result = 0`.
  - Otherwise `result` = two's-complement negation of `mag` if sign, else `mag`, masked to the width, with the upper 32 bits zero for 32-bit ops.
- **Saturating outcomes:** `trap` is always TRAP_NONE.
  - NaN → 0.
  - Overflow positive → INT_MAX (signed) or all-ones (unsigned).
  - Overflow negative → INT_MIN (signed) or 0 (unsigned).
- Negation and saturation are resolved on the SHIFT → DONE edge into registers.
- **DONE:** `out_valid = 1`. `result` and `trap` are driven from registers and held stable until `out_valid && out_ready`, then the state goes to IDLE.
- **`flush`** in any state: next state is IDLE, `out_valid` drops next cycle, and the result is discarded. `flush` in the same cycle as `in_valid` wins, so nothing is accepted.
- **`in_valid` outside IDLE:** ignored; the upstream stage holds it.

## Timing
- **Reset:** state IDLE, `out_valid = 0`, `result = 64'h0`, `trap = TRAP_NONE`.
  - `in_ready` = 1 (the state is IDLE), but `in_valid` is ignored while `rst` is high.
  - Reset mid-operation discards the operation.
- **Latency:**
  - Accept edge at cycle 0 → `out_valid` high in cycle 3.
  - Result handshake in cycle N → `in_ready` high in cycle N+1.
  - Minimum initiation interval is 4 cycles.
- **Outputs:** all registered except `in_ready`, which is decoded from state. No combinational path from `in_valid` or `out_ready` to any output.
- **Simultaneous `rst` and `flush`:** `rst` wins; the outcome is identical either way.

## Test plan
1. **Signed 32-bit, in range and boundary** (`op = 000`):
   - 0xBFF8000000000000 (-1.5) → `result = 0x00000000FFFFFFFF`, TRAP_NONE, `out_valid` at cycle 3.
   - 0x41DFFFFFFFE00000 (2147483647.5) → `0x000000007FFFFFFF`.
   - 0x41E0000000000000 (2^31) → TRAP_INT_OVERFLOW, `result = 0`.
2. **Unsigned 32-bit** (`op = 001`):
   - 0xBFECCCCCCCCCCCCD (-0.9) → 0, TRAP_NONE.
   - 0xBFF0000000000000 (-1.0) → TRAP_INT_OVERFLOW.
   - 0x41EFFFFFFFE00000 (2^32 - 1) → `0x00000000FFFFFFFF`.
3. **Signed 64-bit** (`op = 010`):
   - 0xC3E0000000000000 (-2^63) → `0x8000000000000000`, TRAP_NONE.
   - 0x43E0000000000000 (2^63) → TRAP_INT_OVERFLOW.
   - 0x0000000000000001 (subnormal) → 0.
4. **NaN and Inf:**
   - 0x7FF8000000000000 with `op = 010` → TRAP_INVALID_CONV.
   - Same NaN with `op = 100` → 0, TRAP_NONE.
   - 0x7FF0000000000000 with `op = 111` → `0xFFFFFFFFFFFFFFFF`.
   - 0xFFF0000000000000 with `op = 100` → `0x0000000080000000`.
5. **Backpressure:**
   - `out_ready = 0` for 5 cycles in DONE → `result` and `trap` are stable, `in_ready = 0`, and `in_valid` pulses are not accepted.
   - Then `out_ready = 1` → IDLE, with `in_ready` high the next cycle.
6. **Abort:**
   - `flush` asserted in SHIFT → `out_valid` is never asserted for that op; `in_ready` is high the next cycle; a following op completes normally.
   - Repeat with `rst` instead of `flush`; also hold `rst` high with `in_valid` high → no acceptance.

Source files
------------

// File: rtl/wasm_trunc_f64.sv
// wasm_trunc_f64: multi-cycle f64 -> i32/i64 truncation for the WebAssembly
// trunc_f64_s/u and trunc_sat_f64_s/u instructions. One operation in flight,
// valid/ready on both sides, IDLE -> DECODE -> SHIFT -> DONE -> IDLE.

package wasm_pkg;
  typedef enum logic [1:0] {
    TRAP_NONE         = 2'd0,
    TRAP_INT_OVERFLOW = 2'd1,
    TRAP_INVALID_CONV = 2'd2
  } trap_t;
endpackage

module wasm_trunc_f64
  import wasm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [63:0] operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output trap_t       trap
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  // latched request
  logic [2:0]  op_q;
  logic [63:0] operand_q;

  // decoded fields
  logic              is_nan;
  logic              is_inf;
  logic              exp_zero;
  logic signed [11:0] e;
  logic [52:0]       m;

  // registered outcome
  logic [63:0] result_q;
  trap_t       trap_q;
  logic        out_valid_q;

  // shift-stage combinational values
  logic        big;
  logic [63:0] mag;
  logic [5:0]  sh_right;
  logic [5:0]  sh_left;
  logic        ovf;
  logic [63:0] neg_val;
  logic [63:0] int_val;
  logic [63:0] sat_val;
  logic [63:0] res_next;
  trap_t       trap_next;

  logic accept;
  logic sign;
  logic is_unsigned;
  logic wide;
  logic saturating;

  assign accept      = (state == IDLE) && in_valid && !flush;
  assign sign        = operand_q[63];
  assign is_unsigned = op_q[0];
  assign wide        = op_q[1];
  assign saturating  = op_q[2];

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign trap      = trap_q;

  // State register; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush abandons whatever is in flight, even in IDLE.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_next = DECODE;
        DECODE:  state_next = SHIFT;
        SHIFT:   state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Capture the request on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 3'd0;
      operand_q <= 64'd0;
    end else if (accept) begin
      op_q      <= op;
      operand_q <= operand;
    end
  end

  // Classify the double and split it into unbiased exponent and significand.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_nan   <= 1'b0;
      is_inf   <= 1'b0;
      exp_zero <= 1'b0;
      e        <= 12'sd0;
      m        <= 53'd0;
    end else if (state == DECODE) begin
      is_nan   <= (operand_q[62:52] == 11'h7FF) && (operand_q[51:0] != 52'd0);
      is_inf   <= (operand_q[62:52] == 11'h7FF) && (operand_q[51:0] == 52'd0);
      exp_zero <= (operand_q[62:52] == 11'h000);
      e        <= $signed({1'b0, operand_q[62:52]}) - 12'sd1023;
      m        <= {1'b1, operand_q[51:0]};
    end
  end

  // Align the significand into an integer magnitude, truncating toward zero.
  always_comb begin
    mag      = 64'd0;
    big      = is_inf || (e > 12'sd63);
    sh_right = 6'd52 - e[5:0];
    sh_left  = e[5:0] - 6'd52;
    if (!exp_zero && !big && (e >= 12'sd0)) begin
      if (e <= 12'sd52) mag = {11'd0, m} >> sh_right;
      else              mag = {11'd0, m} << sh_left;
    end
  end

  // Range check against the destination type, then pick the final value/trap.
  always_comb begin
    case ({wide, is_unsigned})
      2'b00:   ovf = big || (sign ? (mag > 64'h0000_0000_8000_0000)
                                  : (mag > 64'h0000_0000_7FFF_FFFF));
      2'b01:   ovf = big || (mag > 64'h0000_0000_FFFF_FFFF) || (sign && (mag != 64'd0));
      2'b10:   ovf = sign ? (big || (mag > 64'h8000_0000_0000_0000)) : (e > 12'sd62);
      default: ovf = big || (sign && (mag != 64'd0));
    endcase

    neg_val = 64'd0 - mag;
    int_val = sign ? neg_val : mag;
    if (!wide) int_val = {32'd0, int_val[31:0]};

    if (!sign) begin
      if (is_unsigned) sat_val = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      else             sat_val = wide ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
    end else begin
      if (is_unsigned) sat_val = 64'd0;
      else             sat_val = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    end

    res_next  = int_val;
    trap_next = TRAP_NONE;
    if (is_nan) begin
      res_next  = 64'd0;
      trap_next = saturating ? TRAP_NONE : TRAP_INVALID_CONV;
    end else if (ovf) begin
      res_next  = saturating ? sat_val : 64'd0;
      trap_next = saturating ? TRAP_NONE : TRAP_INT_OVERFLOW;
    end
  end

  // Register the outcome on the SHIFT -> DONE edge; it holds through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 64'd0;
      trap_q   <= TRAP_NONE;
    end else if ((state == SHIFT) && !flush) begin
      result_q <= res_next;
      trap_q   <= trap_next;
    end
  end

  // out_valid is a flop that mirrors entry into and residence in DONE.
  always_ff @(posedge clk) begin
    if (rst) out_valid_q <= 1'b0;
    else     out_valid_q <= (state_next == DONE);
  end

endmodule

// File: tb/tb_wasm_trunc_f64.sv
// tb_wasm_trunc_f64: directed-vector bench for wasm_trunc_f64 covering
// conversions, traps, saturation, backpressure, flush and reset abort.

module tb_wasm_trunc_f64;
  import wasm_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [63:0] operand;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  trap_t       trap;

  int total = 0;
  int bad   = 0;

  logic [2:0]  vec_op   [$];
  logic [63:0] vec_in   [$];
  logic [63:0] vec_res  [$];
  trap_t       vec_trap [$];

  wasm_trunc_f64 dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .trap      (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] r, input trap_t t);
    vec_op.push_back(o);
    vec_in.push_back(x);
    vec_res.push_back(r);
    vec_trap.push_back(t);
  endtask

  // Offer one operation from IDLE, wait (bounded) for out_valid, take the result.
  task automatic run_op(input logic [2:0] o, input logic [63:0] x,
                        output logic [63:0] r, output trap_t t, output int lat);
    in_valid = 1'b1;
    op       = o;
    operand  = x;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    r = result;
    t = trap;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst      = 1'b1;
    in_valid = 1'b1;
    op       = 3'b000;
    operand  = 64'h3FF0_0000_0000_0000;
    repeat (3) step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
    total++;
    if (result !== 64'd0) begin bad++; $display("[TB] FAIL reset result: got %h want 0", result); end
    total++;
    if (trap !== TRAP_NONE) begin bad++; $display("[TB] FAIL reset trap: got %0d want %0d", trap, TRAP_NONE); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset in_ready: got %b want 1", in_ready); end
    rst      = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("[TB] FAIL reset no_accept: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_conversions();
    logic [63:0] r;
    trap_t       t;
    int          lat;
    // signed 32
    add_vec(3'b000, 64'hBFF8_0000_0000_0000, 64'h0000_0000_FFFF_FFFF, TRAP_NONE);
    add_vec(3'b000, 64'h41DF_FFFF_FFE0_0000, 64'h0000_0000_7FFF_FFFF, TRAP_NONE);
    add_vec(3'b000, 64'h41E0_0000_0000_0000, 64'h0,                   TRAP_INT_OVERFLOW);
    add_vec(3'b000, 64'hC1E0_0000_0000_0000, 64'h0000_0000_8000_0000, TRAP_NONE);
    add_vec(3'b000, 64'hC1E0_0000_0020_0000, 64'h0,                   TRAP_INT_OVERFLOW);
    // unsigned 32
    add_vec(3'b001, 64'hBFEC_CCCC_CCCC_CCCD, 64'h0,                   TRAP_NONE);
    add_vec(3'b001, 64'hBFF0_0000_0000_0000, 64'h0,                   TRAP_INT_OVERFLOW);
    add_vec(3'b001, 64'h41EF_FFFF_FFE0_0000, 64'h0000_0000_FFFF_FFFF, TRAP_NONE);
    add_vec(3'b001, 64'h8000_0000_0000_0000, 64'h0,                   TRAP_NONE);
    // signed 64
    add_vec(3'b010, 64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, TRAP_NONE);
    add_vec(3'b010, 64'h43E0_0000_0000_0000, 64'h0,                   TRAP_INT_OVERFLOW);
    add_vec(3'b010, 64'h0000_0000_0000_0001, 64'h0,                   TRAP_NONE);
    add_vec(3'b010, 64'h4340_0000_0000_0001, 64'h0020_0000_0000_0002, TRAP_NONE);
    // unsigned 64
    add_vec(3'b011, 64'h4059_0000_0000_0000, 64'h0000_0000_0000_0064, TRAP_NONE);
    // NaN / Inf / saturation
    add_vec(3'b010, 64'h7FF8_0000_0000_0000, 64'h0,                   TRAP_INVALID_CONV);
    add_vec(3'b100, 64'h7FF8_0000_0000_0000, 64'h0,                   TRAP_NONE);
    add_vec(3'b111, 64'h7FF0_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, TRAP_NONE);
    add_vec(3'b100, 64'hFFF0_0000_0000_0000, 64'h0000_0000_8000_0000, TRAP_NONE);
    add_vec(3'b110, 64'h43E0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, TRAP_NONE);
    add_vec(3'b101, 64'hC000_0000_0000_0000, 64'h0,                   TRAP_NONE);
    add_vec(3'b100, 64'h41E0_0000_0000_0000, 64'h0000_0000_7FFF_FFFF, TRAP_NONE);

    for (int i = 0; i < vec_in.size(); i++) begin
      run_op(vec_op[i], vec_in[i], r, t, lat);
      total++;
      if (lat != 3) begin bad++; $display("[TB] FAIL vec%0d latency: got %0d want 3", i, lat); end
      total++;
      if (r !== vec_res[i]) begin bad++; $display("[TB] FAIL vec%0d result: got %h want %h", i, r, vec_res[i]); end
      total++;
      if (t !== vec_trap[i]) begin bad++; $display("[TB] FAIL vec%0d trap: got %0d want %0d", i, t, vec_trap[i]); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL vec%0d in_ready_after: got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int unstable;
    int seen;
    in_valid = 1'b1;
    op       = 3'b000;
    operand  = 64'h4059_0000_0000_0000;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    total++;
    if (lat != 3) begin bad++; $display("[TB] FAIL bp latency: got %0d want 3", lat); end
    unstable = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      operand  = 64'hBFF0_0000_0000_0000;
      if (result !== 64'h64 || trap !== TRAP_NONE || in_ready !== 1'b0 || out_valid !== 1'b1)
        unstable++;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (unstable != 0) begin bad++; $display("[TB] FAIL bp hold: got %0d bad cycles want 0", unstable); end
    total++;
    if (result !== 64'h64) begin bad++; $display("[TB] FAIL bp result: got %h want 64", result); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp in_ready: got %b want 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp out_valid_drop: got %b want 0", out_valid); end
    seen = 0;
    repeat (5) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("[TB] FAIL bp no_accept: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_abort();
    logic [63:0] r;
    trap_t       t;
    int          lat;
    int          seen;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      op       = 3'b000;
      operand  = 64'h3FF0_0000_0000_0000;
      step();
      in_valid = 1'b0;
      step();
      if (k == 0) flush = 1'b1;
      else        rst   = 1'b1;
      step();
      flush = 1'b0;
      rst   = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort%0d in_ready: got %b want 1", k, in_ready); end
      seen = (out_valid !== 1'b0) ? 1 : 0;
      repeat (4) begin
        step();
        if (out_valid !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin bad++; $display("[TB] FAIL abort%0d no_valid: got %0d valid cycles want 0", k, seen); end
      run_op(3'b000, 64'hC000_0000_0000_0000, r, t, lat);
      total++;
      if (lat != 3) begin bad++; $display("[TB] FAIL abort%0d next_latency: got %0d want 3", k, lat); end
      total++;
      if (r !== 64'h0000_0000_FFFF_FFFE) begin bad++; $display("[TB] FAIL abort%0d next_result: got %h want 00000000fffffffe", k, r); end
      total++;
      if (t !== TRAP_NONE) begin bad++; $display("[TB] FAIL abort%0d next_trap: got %0d want 0", k, t); end
    end

    // flush together with in_valid in IDLE: nothing is accepted
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    seen = 0;
    repeat (5) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("[TB] FAIL flush_idle no_accept: got %0d valid cycles want 0", seen); end

    // flush while waiting in DONE: out_valid drops on the next cycle
    in_valid = 1'b1;
    operand  = 64'h4059_0000_0000_0000;
    step();
    in_valid = 1'b0;
    step();
    step();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL flush_done valid: got %b want 1", out_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_done drop: got %b want 0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_done in_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'b000;
    operand   = 64'd0;
    out_ready = 1'b0;
    $display("[TB] starting wasm_trunc_f64 bench");
    test_reset();
    test_conversions();
    test_backpressure();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
